irq_ctrl: RTL

//  Parametrised machine-level interrupt controller feeding the core's MTI/EI inputs.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_ctrl_if.sv | 43 ++++
 rtl/irq_gateway.sv | 65 ++++++
 rtl/irq_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//   Shared types and constants for the machine-level interrupt controller.
//   - irq_state_e : claim/complete FSM states
//   - CFG_*       : cfg_sel encodings for the configuration write port
// -----------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_BUSY = 1'b1
  } irq_state_e;

  localparam logic [1:0] CFG_ENABLE    = 2'd0;
  localparam logic [1:0] CFG_EDGE      = 2'd1;
  localparam logic [1:0] CFG_MTIMECMP  = 2'd2;
  localparam logic [1:0] CFG_MTIME_CLR = 2'd3;

  // ID width for NUM_SRC sources plus the reserved "none" ID 0.
  function automatic int unsigned irq_id_width(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
//   Core-side bus of the interrupt controller: configuration writes and the
//   claim/complete handshake.
//   master : core side   (drives cfg_*, claim, complete, complete_id)
//   slave  : controller  (drives claim_id)
//   Signals:
//     cfg_we       config write strobe
//     cfg_sel      0=enable mask, 1=edge-mode mask, 2=mtimecmp, 3=clear mtime
//     cfg_wdata    config write data (masks use bits [NUM_SRC-1:0])
//     claim        1-cycle pulse, claim highest-priority pending source
//     claim_id     claimed ID, valid the cycle after claim (0 = none)
//     complete     1-cycle pulse, servicing finished
//     complete_id  ID being completed
// -----------------------------------------------------------------------------
interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned TIMER_W = 32
);

  localparam int unsigned ID_W = irq_id_width(NUM_SRC);

  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [TIMER_W-1:0] cfg_wdata;
  logic               claim;
  logic [ID_W-1:0]    claim_id;
  logic               complete;
  logic [ID_W-1:0]    complete_id;

  modport master (
    output cfg_we, cfg_sel, cfg_wdata, claim, complete, complete_id,
    input  claim_id
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_wdata, claim, complete, complete_id,
    output claim_id
  );

endinterface

// File: rtl/irq_gateway.sv
// -----------------------------------------------------------------------------
// irq_gateway
//   Per-source interrupt gateway: 2-flop synchroniser plus a history flop for
//   edge detection, and the pending / in_flight state bits for one source.
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-low
//     src        raw interrupt line (asynchronous to clk)
//     edge_mode  1 = set pending on synced 0->1, 0 = set while synced level high
//     clr        source is being claimed this cycle
//     done       claimed source is being completed this cycle
//     pending    latched request
//     in_flight  source claimed and not yet completed
// -----------------------------------------------------------------------------
module irq_gateway (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  input  logic done,
  output logic pending,
  output logic in_flight
);

  logic sync1, sync2, hist;
  logic set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // A source already in service cannot re-pend until it is completed.
  assign set = !in_flight && (edge_mode ? (sync2 && !hist) : sync2);

  // clr has priority over set, so a claim always wins a same-cycle re-trigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= 1'b0;
    end else if (clr) begin
      in_flight <= 1'b1;
    end else if (done) begin
      in_flight <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Machine-level interrupt controller feeding the core's MTI/EI inputs.
//   NUM_SRC external sources with per-source enable and edge/level mode,
//   fixed-priority (lowest index wins, ID = index+1) claim/complete handshake,
//   and a free-running mtime compared against mtimecmp to raise MTI.
//   Ports:
//     clk     clock, all state on rising edge
//     reset   asynchronous, active-low
//     src     raw interrupt lines (asynchronous to clk)
//     bus     irq_ctrl_if.slave: config writes and claim/complete handshake
//     EI      external interrupt request (registered, 0 while a claim is open)
//     MTI     machine timer interrupt (registered mtime >= mtimecmp)
//     mtime   current timer value
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  irq_ctrl_if.slave          bus,
  output logic               EI,
  output logic               MTI,
  output logic [TIMER_W-1:0] mtime
);

  localparam int unsigned ID_W = irq_id_width(NUM_SRC);

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [TIMER_W-1:0] mtimecmp_q;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_flight;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] done_vec;

  logic [ID_W-1:0]    best_id;
  logic [NUM_SRC-1:0] best_oh;

  irq_state_e         state_q, state_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               ei_d;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q   <= '0;
      edge_q     <= '0;
      mtimecmp_q <= '1;
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        CFG_ENABLE:   enable_q   <= bus.cfg_wdata[NUM_SRC-1:0];
        CFG_EDGE:     edge_q     <= bus.cfg_wdata[NUM_SRC-1:0];
        CFG_MTIMECMP: mtimecmp_q <= bus.cfg_wdata;
        default:      ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
    end else if (bus.cfg_we && (bus.cfg_sel == CFG_MTIME_CLR)) begin
      mtime <= '0;
    end else begin
      mtime <= mtime + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MTI <= 1'b0;
    end else begin
      MTI <= (mtime >= mtimecmp_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Gateways
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk       (clk),
      .reset     (reset),
      .src       (src[g]),
      .edge_mode (edge_q[g]),
      .clr       (clr_vec[g]),
      .done      (done_vec[g]),
      .pending   (pending[g]),
      .in_flight (in_flight[g])
    );
  end

  assign active = pending & enable_q;

  // ---------------------------------------------------------------------------
  // Priority encoder: lowest active index wins
  // ---------------------------------------------------------------------------
  always_comb begin
    best_id = '0;
    best_oh = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[i] && (best_id == '0)) begin
        best_id    = ID_W'(i + 1);
        best_oh[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Claim/complete FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IRQ_IDLE;
      claim_id_q <= '0;
      EI         <= 1'b0;
    end else begin
      state_q    <= state_d;
      claim_id_q <= claim_id_d;
      EI         <= ei_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    clr_vec    = '0;
    done_vec   = '0;
    case (state_q)
      IRQ_IDLE: begin
        if (bus.claim) begin
          claim_id_d = best_id;
          clr_vec    = best_oh;
          if (best_id != '0) state_d = IRQ_BUSY;
        end
      end
      IRQ_BUSY: begin
        // claim_id_q is never 0 in BUSY, so complete_id 0 can never match.
        if (bus.complete && (bus.complete_id == claim_id_q)) begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            done_vec[i] = (claim_id_q == ID_W'(i + 1));
          end
          claim_id_d = '0;
          state_d    = IRQ_IDLE;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    // EI follows the next state so it drops in the same cycle claim_id appears.
    ei_d = (state_d == IRQ_IDLE) && (active != '0);
  end

  assign bus.claim_id = claim_id_q;

endmodule
